// File: rtl/spi_ram_pkg.sv
// ---------------------------------------------------------------------------
// spi_ram_pkg
// Shared types and constants for the SPI RAM controller.
//   cmd_e          : 2-bit command prefix carried in rx_data[ADDR_SIZE+1:ADDR_SIZE]
//   state_e        : controller FSM states
//   tx_hold_cycles : number of cycles tx_valid stays high for one read
// ---------------------------------------------------------------------------
package spi_ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RD_ACCESS = 2'b01,
      TX_HOLD   = 2'b10
   } state_e;

   // The slave needs one cycle per data bit plus one to load its shifter.
   function automatic int tx_hold_cycles(input int addr_size);
      return addr_size + 1;
   endfunction

endpackage

// File: rtl/spi_ram_ctrl_core.sv
// ---------------------------------------------------------------------------
// sp_ram_core
// Single-port storage array: synchronous write, registered read.
// A write and a read to the same address on the same edge return the old
// contents (read-before-write).
// Ports:
//   clk  : clock, rising edge
//   we   : write enable
//   addr : shared read/write address
//   din  : write data
//   dout : registered read data (mem[addr] sampled every edge)
// Memory contents are not reset.
// ---------------------------------------------------------------------------
module sp_ram_core #(
   parameter int ADDR_SIZE = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [ADDR_SIZE-1:0] din,
   output logic [ADDR_SIZE-1:0] dout
);

   logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Command-decoding RAM controller fed by an SPI slave.
// Ports:
//   clk      : sole clock, rising edge
//   rst      : synchronous active-high reset
//   rx_data  : {cmd[1:0], payload[ADDR_SIZE-1:0]}
//   rx_valid : one-cycle strobe qualifying rx_data
//   tx_data  : read data, held until the next read completes
//   tx_valid : high for tx_hold_cycles(ADDR_SIZE) cycles per read
//   rd_err   : one-cycle pulse when a read-data command is rejected
// Handshake: rx_valid is a fire-and-forget strobe (no back-pressure); a
//   word is consumed on every edge where rx_valid=1. tx_valid is a level
//   that the slave samples for the whole shift window; there is no ready.
// Optional feature macro: SPI_RAM_AUTOINC_EN
//   defined   : wr_addr advances after each 01 command, rd_addr after each
//               accepted 11 command, and rd_addr_seen stays set (bursts).
//   undefined : addresses change only on 00/10, rd_addr_seen clears on read.
// ---------------------------------------------------------------------------
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE+1:0] rx_data,
   input  logic                 rx_valid,
   output logic [ADDR_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   output logic                 rd_err
);

   localparam int HOLD  = tx_hold_cycles(ADDR_SIZE);
   localparam int CNT_W = $clog2(HOLD + 1);
   localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);

   cmd_e                 cmd;
   logic [ADDR_SIZE-1:0] payload;
   state_e               state;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 rd_addr_seen;
   logic [CNT_W-1:0]     hold_cnt;
   logic                 rd_oor;
   logic [ADDR_SIZE-1:0] rd_buf;

   logic                 wr_in_range;
   logic                 rd_in_range;
   logic                 rd_cmd;
   logic                 rd_ok;
   logic                 ram_we;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [ADDR_SIZE-1:0] ram_dout;

   assign cmd     = cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
   assign payload = rx_data[ADDR_SIZE-1:0];

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

   assign rd_cmd = rx_valid && (cmd == CMD_RD_DATA);
   assign rd_ok  = rd_cmd && (state == IDLE) && rd_addr_seen;

   // The port serves writes when one is present and otherwise sits on
   // rd_addr. The accepted read edge always carries a 11 command, so the
   // array read for a request is taken on that same edge without conflict,
   // and any write in RD_ACCESS lands after it (read-before-write).
   assign ram_we   = rx_valid && (cmd == CMD_WR_DATA) && wr_in_range;
   assign ram_addr = ram_we ? wr_addr : rd_addr;

`ifdef SPI_RAM_AUTOINC_EN
   logic [ADDR_SIZE-1:0] wr_next;
   logic [ADDR_SIZE-1:0] rd_next;
   // Wrap to 0 at MEM_DEPTH; an out-of-range pointer also restarts at 0.
   assign wr_next = (({1'b0, wr_addr} + (ADDR_SIZE+1)'(1)) >= DEPTH_W) ?
                    '0 : wr_addr + ADDR_SIZE'(1);
   assign rd_next = (({1'b0, rd_addr} + (ADDR_SIZE+1)'(1)) >= DEPTH_W) ?
                    '0 : rd_addr + ADDR_SIZE'(1);
`endif

   sp_ram_core #(
      .ADDR_SIZE (ADDR_SIZE),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_core (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (payload),
      .dout (ram_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         rd_addr_seen <= 1'b0;
         hold_cnt     <= '0;
         rd_oor       <= 1'b0;
         rd_buf       <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         rd_err       <= 1'b0;
      end else begin
         rd_err <= rd_cmd && !rd_ok;

         // Command decode: address and data commands are honoured in every
         // state; only the read request depends on the FSM.
         if (rx_valid) begin
            unique case (cmd)
               CMD_WR_ADDR: wr_addr <= payload;
               CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                  wr_addr <= wr_next;
`endif
               end
               CMD_RD_ADDR: begin
                  rd_addr      <= payload;
                  rd_addr_seen <= 1'b1;
               end
               CMD_RD_DATA: begin
                  if (rd_ok) begin
`ifdef SPI_RAM_AUTOINC_EN
                     rd_addr <= rd_next;
`else
                     rd_addr_seen <= 1'b0;
`endif
                  end
               end
            endcase
         end

         unique case (state)
            IDLE: begin
               if (rd_ok) begin
                  rd_oor <= !rd_in_range;
                  state  <= RD_ACCESS;
               end
            end
            RD_ACCESS: begin
               // ram_dout still holds the value read on the request edge.
               rd_buf   <= rd_oor ? '0 : ram_dout;
               hold_cnt <= '0;
               state    <= TX_HOLD;
            end
            TX_HOLD: begin
               if (!tx_valid) begin
                  tx_data  <= rd_buf;
                  tx_valid <= 1'b1;
                  hold_cnt <= CNT_W'(1);
               end else if (hold_cnt == CNT_W'(HOLD)) begin
                  tx_valid <= 1'b0;
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_ctrl
// Directed plus a few random write/read pairs against spi_ram_ctrl built
// with MEM_DEPTH=200 so the out-of-range path is reachable. Expected read
// data is pushed to exp_q when a read is issued and popped when tx_valid
// rises. Honours SPI_RAM_AUTOINC_EN.
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;

   localparam int AS    = 8;
   localparam int DEPTH = 200;
   localparam int HOLD  = AS + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [AS+1:0] rx_data;
   logic          rx_valid;
   logic [AS-1:0] tx_data;
   logic          tx_valid;
   logic          rd_err;

   int            checks = 0;
   int            passed = 0;
   logic [AS-1:0] exp_q[$];
   logic [AS-1:0] model [256];
   int            m_wr = 0;
   int            m_rd = 0;
   bit            m_seen = 1'b0;
   bit            skip_len = 1'b0;
   bit            prev_valid = 1'b0;
   int            run_len = 0;

   // clock / reset
   always #5 clk = ~clk;

   spi_ram_ctrl #(
      .ADDR_SIZE (AS),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .rd_err   (rd_err)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // driver tasks: each strobe is sampled on the rising edge between two
   // falling edges; tasks return on the falling edge right after it.
   task automatic send(input logic [1:0] c, input logic [AS-1:0] p);
      @(negedge clk);
      rx_data  = {c, p};
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic set_wr(input int a);
      send(2'b00, AS'(a));
      m_wr = a;
   endtask

   task automatic put_data(input logic [AS-1:0] d);
      send(2'b01, d);
      if (m_wr < DEPTH) model[m_wr] = d;
`ifdef SPI_RAM_AUTOINC_EN
      m_wr = (m_wr >= DEPTH - 1) ? 0 : m_wr + 1;
`endif
   endtask

   task automatic set_rd(input int a);
      send(2'b10, AS'(a));
      m_rd   = a;
      m_seen = 1'b1;
   endtask

   // Read request issued from IDLE.
   task automatic do_read();
      send(2'b11, '0);
      if (m_seen) begin
         exp_q.push_back((m_rd < DEPTH) ? model[m_rd] : '0);
`ifdef SPI_RAM_AUTOINC_EN
         m_rd = (m_rd >= DEPTH - 1) ? 0 : m_rd + 1;
`else
         m_seen = 1'b0;
`endif
      end
   endtask

   task automatic wait_idle();
      repeat (12) @(negedge clk);
   endtask

   // scoreboard monitor
   always @(posedge clk) begin
      #1;
      if (tx_valid === 1'b1 && !prev_valid) begin
         if (exp_q.size() == 0) check("tx_unexpected", 32'(tx_valid), 32'd0);
         else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
         run_len = 1;
      end else if (tx_valid === 1'b1) begin
         run_len++;
      end else if (prev_valid && !skip_len) begin
         check("tx_valid_len", 32'(run_len), 32'(HOLD));
      end
      prev_valid = (tx_valid === 1'b1);
   end

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_rd_err",   32'(rd_err),   32'd0);

      // read without address
      do_read();
      check("noaddr_rd_err", 32'(rd_err), 32'd1);
      @(negedge clk);
      check("noaddr_rd_err_clr", 32'(rd_err), 32'd0);
      repeat (3) @(negedge clk);
      check("noaddr_tx_valid", 32'(tx_valid), 32'd0);

      // write then read, with latency
      set_wr(8'h10);
      put_data(8'hA5);
      set_rd(8'h10);
      do_read();
      check("lat_edge0", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("lat_edge1", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("lat_edge2", 32'(tx_valid), 32'd1);
      check("lat_data",  32'(tx_data),  32'hA5);
      wait_idle();
      check("hold_done", 32'(tx_valid), 32'd0);
      check("data_held", 32'(tx_data),  32'hA5);

      // second read request during the hold window
      set_rd(8'h10);
      do_read();
      repeat (3) @(negedge clk);
      send(2'b11, '0);
      check("hold_rd_err", 32'(rd_err), 32'd1);
      wait_idle();

      // out of range: write dropped, read returns 0
      set_wr(8'hF0);
      put_data(8'h33);
      set_rd(8'hF0);
      do_read();
      wait_idle();

      // random in-range pairs
      for (int i = 0; i < 4; i++) begin
         int a;
         logic [AS-1:0] d;
         a = $urandom_range(0, DEPTH - 1);
         d = AS'($urandom_range(0, 255));
         set_wr(a);
         put_data(d);
         set_rd(a);
         do_read();
         wait_idle();
      end

      // reset on the 4th tx_valid cycle
      set_wr(8'h10);
      put_data(8'h5C);
      set_rd(8'h10);
      do_read();
      skip_len = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_valid_before_rst", 32'(tx_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_wr = 0;
      m_rd = 0;
      m_seen = 1'b0;
      check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      check("mid_rst_tx_data",  32'(tx_data),  32'd0);
      skip_len = 1'b0;
      do_read();
      check("post_rst_rd_err", 32'(rd_err), 32'd1);
      wait_idle();

`ifdef SPI_RAM_AUTOINC_EN
      // burst write across the wrap point, then burst read
      set_wr(DEPTH - 2);
      put_data(8'h01);
      put_data(8'h02);
      put_data(8'h03);
      set_rd(DEPTH - 2);
      for (int i = 0; i < 3; i++) begin
         do_read();
         wait_idle();
      end
`else
      // addresses do not advance; rd_addr_seen clears after each read
      set_wr(8'h21);
      put_data(8'h77);
      set_wr(8'h20);
      put_data(8'h11);
      put_data(8'h22);
      set_rd(8'h20);
      do_read();
      wait_idle();
      set_rd(8'h21);
      do_read();
      wait_idle();
      do_read();
      check("seen_cleared_rd_err", 32'(rd_err), 32'd1);
      wait_idle();
`endif

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
